cbus_arbiter: RTL and testbench

- Shares one split-handshake memory bus between the instruction-fetch requester (ibus) and the data-access requester (dbus) of the core.
- Allows at most one outstanding transaction. The grant is locked from issue until data_ok.
- Routes addr_ok, data_ok and read data back to the granted requester only.
- Sits between the core's fetch/memory stages and the memory/cache interface.

---
 rtl/cbus_arbiter.sv | 149 ++++++++++++++
 tb/tb_cbus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_arbiter.sv
// cbus_arbiter
// Shares one split-handshake memory bus between the instruction-fetch
// requester (ibus) and the data-access requester (dbus). Only one
// transaction can be outstanding at a time. The grant is held from issue
// until data_ok. Handshakes and read data go back to the granted requester
// only.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   ireq_* / i_*         instruction requester: request in, addr_ok/data_ok/data out
//   dreq_* / d_*         data requester: request (with strobe/write data) in, responses out
//   creq_* / c_*         downstream bus: request out, addr_ok/data_ok/data in
//
// Parameters
//   ROUND_ROBIN  0 = data always wins a tie, 1 = alternate on ties (data first)
//   ADDR_W       address width
//   DATA_W       data width
module cbus_arbiter #(
  parameter int ROUND_ROBIN = 0,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  input  logic [2:0]          ireq_size,
  output logic                i_addr_ok,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_data,
  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_data,
  output logic                d_addr_ok,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_data,
  output logic                creq_valid,
  output logic [ADDR_W-1:0]   creq_addr,
  output logic [2:0]          creq_size,
  output logic [DATA_W/8-1:0] creq_strobe,
  output logic [DATA_W-1:0]   creq_data,
  input  logic                c_addr_ok,
  input  logic                c_data_ok,
  input  logic [DATA_W-1:0]   c_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;      // 0 = instruction, 1 = data
  logic   rr_last_q, rr_last_d;  // last requester issued, for round-robin ties

  logic sel_data;
  logic owner;
  logic owner_valid;

  // Arbitration and ownership. In IDLE the owner is whoever wins arbitration
  // this cycle. Otherwise it is the locked grant.
  always_comb begin
    sel_data = dreq_valid;
    if (ireq_valid && dreq_valid) begin
      sel_data = (ROUND_ROBIN != 0) ? ~rr_last_q : 1'b1;
    end
    owner       = (state_q == IDLE) ? sel_data : grant_q;
    owner_valid = owner ? dreq_valid : ireq_valid;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
    end
  end

  // A dropped valid in ADDR freezes the FSM instead of completing a request
  // that the requester no longer holds.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (ireq_valid || dreq_valid) begin
          grant_d   = sel_data;
          rr_last_d = sel_data;
          if (!c_addr_ok) begin
            state_d = ADDR;
          end else if (!c_data_ok) begin
            state_d = DATA;
          end
        end
      end
      ADDR: begin
        if (owner_valid && c_addr_ok) begin
          state_d = c_data_ok ? IDLE : DATA;
        end
      end
      DATA: begin
        if (c_data_ok) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic issuing;
  logic addr_hit;
  logic data_hit;

  // Outputs are gated by resetn so that they drop to zero as soon as reset
  // asserts, even when a requester still holds valid. A data_ok in IDLE/ADDR
  // is only routed when it pairs with an accepted address. A data_ok in IDLE
  // with no issue is stale and is ignored.
  always_comb begin
    issuing     = resetn && owner_valid && (state_q == IDLE || state_q == ADDR);
    addr_hit    = issuing && c_addr_ok;
    data_hit    = (addr_hit && c_data_ok) || (resetn && state_q == DATA && c_data_ok);
    creq_valid  = issuing;
    creq_addr   = '0;
    creq_size   = '0;
    creq_strobe = '0;
    creq_data   = '0;
    if (issuing) begin
      creq_addr   = owner ? dreq_addr : ireq_addr;
      creq_size   = owner ? dreq_size : ireq_size;
      creq_strobe = owner ? dreq_strobe : '0;
      creq_data   = owner ? dreq_data : '0;
    end
    i_addr_ok = addr_hit && !owner;
    d_addr_ok = addr_hit && owner;
    i_data_ok = data_hit && !owner;
    d_data_ok = data_hit && owner;
    i_data    = i_data_ok ? c_data : '0;
    d_data    = d_data_ok ? c_data : '0;
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter
// Directed bench for cbus_arbiter. Two instances share every input:
// dut0 uses fixed priority and dut1 uses round-robin. Each test task drives
// inputs one time unit after the rising edge. It then checks the
// combinational outputs at the falling edge against hand-computed values.
module tb_cbus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ireq_valid, dreq_valid, c_addr_ok, c_data_ok;
  logic [AW-1:0] ireq_addr, dreq_addr;
  logic [2:0]    ireq_size, dreq_size;
  logic [SW-1:0] dreq_strobe;
  logic [DW-1:0] dreq_data, c_data;

  logic          i_addr_ok_0, i_data_ok_0, d_addr_ok_0, d_data_ok_0, creq_valid_0;
  logic [DW-1:0] i_data_0, d_data_0, creq_data_0;
  logic [AW-1:0] creq_addr_0;
  logic [2:0]    creq_size_0;
  logic [SW-1:0] creq_strobe_0;

  logic          i_addr_ok_1, i_data_ok_1, d_addr_ok_1, d_data_ok_1, creq_valid_1;
  logic [DW-1:0] i_data_1, d_data_1, creq_data_1;
  logic [AW-1:0] creq_addr_1;
  logic [2:0]    creq_size_1;
  logic [SW-1:0] creq_strobe_1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cbus_arbiter #(.ROUND_ROBIN(0), .ADDR_W(AW), .DATA_W(DW)) dut0 (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_size(ireq_size),
    .i_addr_ok(i_addr_ok_0), .i_data_ok(i_data_ok_0), .i_data(i_data_0),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .d_addr_ok(d_addr_ok_0), .d_data_ok(d_data_ok_0), .d_data(d_data_0),
    .creq_valid(creq_valid_0), .creq_addr(creq_addr_0), .creq_size(creq_size_0),
    .creq_strobe(creq_strobe_0), .creq_data(creq_data_0),
    .c_addr_ok(c_addr_ok), .c_data_ok(c_data_ok), .c_data(c_data)
  );

  cbus_arbiter #(.ROUND_ROBIN(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
    .clk(clk), .resetn(resetn),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_size(ireq_size),
    .i_addr_ok(i_addr_ok_1), .i_data_ok(i_data_ok_1), .i_data(i_data_1),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .d_addr_ok(d_addr_ok_1), .d_data_ok(d_data_ok_1), .d_data(d_data_1),
    .creq_valid(creq_valid_1), .creq_addr(creq_addr_1), .creq_size(creq_size_1),
    .creq_strobe(creq_strobe_1), .creq_data(creq_data_1),
    .c_addr_ok(c_addr_ok), .c_data_ok(c_data_ok), .c_data(c_data)
  );

  logic [139:0] outs_0, outs_1;
  assign outs_0 = {i_addr_ok_0, i_data_ok_0, i_data_0, d_addr_ok_0, d_data_ok_0, d_data_0,
                   creq_valid_0, creq_addr_0, creq_size_0, creq_strobe_0, creq_data_0};
  assign outs_1 = {i_addr_ok_1, i_data_ok_1, i_data_1, d_addr_ok_1, d_data_ok_1, d_data_1,
                   creq_valid_1, creq_addr_1, creq_size_1, creq_strobe_1, creq_data_1};

  // The granted requester must keep valid asserted while the FSM waits for
  // address acceptance.
  always @(posedge clk) begin
    if (resetn && dut0.state_q == 2'd1) begin
      assert (dut0.grant_q ? dreq_valid : ireq_valid)
        else $error("[TB] protocol: granted requester dropped valid while waiting for addr_ok");
    end
  end

  task automatic idle_inputs();
    ireq_valid = 1'b0; ireq_addr = '0; ireq_size = 3'd0;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_size = 3'd0;
    dreq_strobe = '0;  dreq_data = '0;
    c_addr_ok = 1'b0;  c_data_ok = 1'b0; c_data = '0;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle_inputs();
    advance();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    ireq_valid = 1'b1; ireq_addr = 32'h100;
    dreq_valid = 1'b1; dreq_addr = 32'h200; dreq_strobe = 4'hF; dreq_data = 32'h1;
    c_addr_ok = 1'b1; c_data_ok = 1'b1; c_data = 32'hFFFF_FFFF;
    sample();
    total++; if (outs_0 !== '0) begin bad++; $display("[TB] FAIL reset_outs0: got %h want 0", outs_0); end
    total++; if (outs_1 !== '0) begin bad++; $display("[TB] FAIL reset_outs1: got %h want 0", outs_1); end
    idle_inputs();
    advance();
    resetn = 1'b1;
    sample();
    total++; if (outs_0 !== '0) begin bad++; $display("[TB] FAIL idle_outs0: got %h want 0", outs_0); end
    advance();
  endtask

  task automatic test_inst_only();
    ireq_valid = 1'b1; ireq_addr = 32'hBFC0_0000; ireq_size = 3'd2;
    dreq_data = 32'h5555_5555; c_addr_ok = 1'b1;
    sample();
    total++; if (creq_valid_0 !== 1'b1) begin bad++; $display("[TB] FAIL inst_creq_valid: got %b want 1", creq_valid_0); end
    total++; if (creq_addr_0 !== 32'hBFC0_0000) begin bad++; $display("[TB] FAIL inst_creq_addr: got %h want bfc00000", creq_addr_0); end
    total++; if ({i_addr_ok_0, d_addr_ok_0} !== 2'b10) begin bad++; $display("[TB] FAIL inst_addr_ok: got %b want 10", {i_addr_ok_0, d_addr_ok_0}); end
    total++; if (creq_data_0 !== '0) begin bad++; $display("[TB] FAIL inst_creq_data: got %h want 0", creq_data_0); end
    advance();
    ireq_valid = 1'b0; c_addr_ok = 1'b0;
    sample();
    total++; if ({creq_valid_0, i_data_ok_0} !== 2'b00) begin bad++; $display("[TB] FAIL inst_wait: got %b want 00", {creq_valid_0, i_data_ok_0}); end
    advance();
    c_data_ok = 1'b1; c_data = 32'h2408_0001;
    sample();
    total++; if (i_data_ok_0 !== 1'b1) begin bad++; $display("[TB] FAIL inst_data_ok: got %b want 1", i_data_ok_0); end
    total++; if (i_data_0 !== 32'h2408_0001) begin bad++; $display("[TB] FAIL inst_data: got %h want 24080001", i_data_0); end
    total++; if ({d_data_ok_0, d_data_0} !== 33'h0) begin bad++; $display("[TB] FAIL inst_d_quiet: got %h want 0", {d_data_ok_0, d_data_0}); end
    total++; if (i_data_1 !== 32'h2408_0001) begin bad++; $display("[TB] FAIL inst_data_rr: got %h want 24080001", i_data_1); end
    advance();
    idle_inputs();
  endtask

  task automatic test_fixed_priority();
    ireq_valid = 1'b1; ireq_addr = 32'h1000;
    dreq_valid = 1'b1; dreq_addr = 32'h2000;
    c_addr_ok = 1'b1; c_data_ok = 1'b1; c_data = 32'h77;
    for (int k = 0; k < 4; k++) begin
      sample();
      total++; if ({i_addr_ok_0, d_addr_ok_0} !== 2'b01) begin bad++; $display("[TB] FAIL prio_grant[%0d]: got %b want 01", k, {i_addr_ok_0, d_addr_ok_0}); end
      total++; if (creq_addr_0 !== 32'h2000) begin bad++; $display("[TB] FAIL prio_addr[%0d]: got %h want 2000", k, creq_addr_0); end
      total++; if (d_data_0 !== 32'h77) begin bad++; $display("[TB] FAIL prio_data[%0d]: got %h want 77", k, d_data_0); end
      total++; if ({i_addr_ok_1, d_addr_ok_1} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("[TB] FAIL rr1_grant[%0d]: got %b want %b", k, {i_addr_ok_1, d_addr_ok_1}, (k % 2 == 0) ? 2'b01 : 2'b10); end
      advance();
    end
    dreq_valid = 1'b0;
    sample();
    total++; if ({i_addr_ok_0, d_addr_ok_0} !== 2'b10) begin bad++; $display("[TB] FAIL prio_inst_alone: got %b want 10", {i_addr_ok_0, d_addr_ok_0}); end
    advance();
    idle_inputs();
  endtask

  task automatic test_round_robin();
    do_reset();
    ireq_valid = 1'b1; ireq_addr = 32'h1000;
    dreq_valid = 1'b1; dreq_addr = 32'h2000;
    for (int k = 0; k < 4; k++) begin
      c_addr_ok = 1'b1; c_data_ok = 1'b0;
      sample();
      total++; if ({i_addr_ok_1, d_addr_ok_1} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("[TB] FAIL rr_grant[%0d]: got %b want %b", k, {i_addr_ok_1, d_addr_ok_1}, (k % 2 == 0) ? 2'b01 : 2'b10); end
      total++; if (creq_addr_1 !== ((k % 2 == 0) ? 32'h2000 : 32'h1000)) begin bad++; $display("[TB] FAIL rr_addr[%0d]: got %h want %h", k, creq_addr_1, (k % 2 == 0) ? 32'h2000 : 32'h1000); end
      advance();
      c_addr_ok = 1'b0; c_data_ok = 1'b1; c_data = 32'(k);
      sample();
      total++; if (creq_valid_1 !== 1'b0) begin bad++; $display("[TB] FAIL rr_gap[%0d]: got %b want 0", k, creq_valid_1); end
      total++; if ({i_data_ok_1, d_data_ok_1} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("[TB] FAIL rr_resp[%0d]: got %b want %b", k, {i_data_ok_1, d_data_ok_1}, (k % 2 == 0) ? 2'b01 : 2'b10); end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_write_stall();
    int pulses;
    pulses = 0;
    do_reset();
    dreq_valid = 1'b1; dreq_addr = 32'h8000_0010; dreq_size = 3'd2;
    dreq_strobe = 4'hF; dreq_data = 32'hDEAD_BEEF;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc == 1) begin ireq_valid = 1'b1; ireq_addr = 32'h100; end
      c_addr_ok = (cyc == 3);
      sample();
      total++; if ({creq_valid_0, creq_addr_0, creq_strobe_0, creq_data_0} !== {1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF}) begin
        bad++; $display("[TB] FAIL wr_hold[%0d]: got %b/%h/%h/%h", cyc, creq_valid_0, creq_addr_0, creq_strobe_0, creq_data_0);
      end
      total++; if (i_addr_ok_0 !== 1'b0) begin bad++; $display("[TB] FAIL wr_i_blocked[%0d]: got %b want 0", cyc, i_addr_ok_0); end
      if (d_addr_ok_0 === 1'b1) pulses++;
      advance();
    end
    dreq_valid = 1'b0; c_addr_ok = 1'b0;
    sample();
    total++; if ({creq_valid_0, i_addr_ok_0} !== 2'b00) begin bad++; $display("[TB] FAIL wr_data_wait: got %b want 00", {creq_valid_0, i_addr_ok_0}); end
    advance();
    c_data_ok = 1'b1;
    sample();
    total++; if ({d_data_ok_0, i_addr_ok_0, creq_valid_0} !== 3'b100) begin bad++; $display("[TB] FAIL wr_done: got %b want 100", {d_data_ok_0, i_addr_ok_0, creq_valid_0}); end
    advance();
    c_addr_ok = 1'b1; c_data_ok = 1'b1;
    sample();
    total++; if ({i_addr_ok_0, creq_addr_0, creq_strobe_0} !== {1'b1, 32'h100, 4'h0}) begin bad++; $display("[TB] FAIL wr_then_inst: got %b/%h/%h", i_addr_ok_0, creq_addr_0, creq_strobe_0); end
    total++; if (pulses !== 1) begin bad++; $display("[TB] FAIL wr_addr_ok_pulses: got %0d want 1", pulses); end
    advance();
    idle_inputs();
  endtask

  task automatic test_same_cycle();
    ireq_valid = 1'b1; ireq_addr = 32'h100;
    c_addr_ok = 1'b1; c_data_ok = 1'b1; c_data = 32'h1234;
    sample();
    total++; if ({i_addr_ok_0, i_data_ok_0, i_data_0} !== {2'b11, 32'h1234}) begin bad++; $display("[TB] FAIL same_cycle: got %b%b/%h", i_addr_ok_0, i_data_ok_0, i_data_0); end
    advance();
    ireq_addr = 32'h104;
    sample();
    total++; if ({creq_valid_0, creq_addr_0, i_addr_ok_0} !== {1'b1, 32'h104, 1'b1}) begin bad++; $display("[TB] FAIL same_next_issue: got %b/%h/%b", creq_valid_0, creq_addr_0, i_addr_ok_0); end
    advance();
    idle_inputs();
  endtask

  task automatic test_reset_mid_data();
    ireq_valid = 1'b1; ireq_addr = 32'h200; ireq_size = 3'd2;
    c_addr_ok = 1'b1; c_data_ok = 1'b0;
    advance();
    c_addr_ok = 1'b0;
    #1;
    resetn = 1'b0; c_data_ok = 1'b1; c_data = 32'hAAAA_5555;
    #1;
    total++; if (outs_0 !== '0) begin bad++; $display("[TB] FAIL mid_reset_outs: got %h want 0", outs_0); end
    #1;
    resetn = 1'b1;
    #1;
    total++; if ({creq_valid_0, creq_addr_0} !== {1'b1, 32'h200}) begin bad++; $display("[TB] FAIL post_reset_issue: got %b/%h", creq_valid_0, creq_addr_0); end
    total++; if ({i_addr_ok_0, i_data_ok_0} !== 2'b00) begin bad++; $display("[TB] FAIL stale_data_ok: got %b want 00", {i_addr_ok_0, i_data_ok_0}); end
    advance();
    c_data_ok = 1'b0; c_addr_ok = 1'b1;
    sample();
    total++; if (i_addr_ok_0 !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_addr_ok: got %b want 1", i_addr_ok_0); end
    advance();
    ireq_valid = 1'b0; c_addr_ok = 1'b0; c_data_ok = 1'b1; c_data = 32'h33;
    sample();
    total++; if ({i_data_ok_0, i_data_0} !== {1'b1, 32'h33}) begin bad++; $display("[TB] FAIL post_reset_data: got %b/%h", i_data_ok_0, i_data_0); end
    advance();
    idle_inputs();
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_inst_only();
    test_fixed_priority();
    test_round_robin();
    test_write_stall();
    test_same_cycle();
    test_reset_mid_data();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
